// File: rtl/audio_pkg.sv
// Shared definitions for the WM8731 audio-in capture path: framer states,
// channel encoding and the default channel word width.
package audio_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } frame_state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/audio_in_fifo.sv
// Synchronous show-ahead FIFO for captured sample pairs. Clear beats push/pop;
// a push into a full FIFO only succeeds when a pop happens in the same cycle.
module audio_in_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // The extra pointer MSB separates "full" from "empty" when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = i_pop && !o_empty && !i_clear;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_clear;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // NOTE: storage is deliberately left without reset; the pointers alone define
  // which entries are valid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/audio_in_receiver.sv
// WM8731 I2S capture: oversampled serial inputs, ALIGN/DELAY/SHIFT/HOLD framer
// and a show-ahead pair FIFO. Define AUDIO_IN_PEAK_EN to add the peak_level output.
module audio_in_receiver
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  input  logic                  clear_audio_in_memory,
  input  logic                  read_audio_in,
  output logic                  audio_in_available,
  output logic [DATA_WIDTH-1:0] left_channel_audio_in,
  output logic [DATA_WIDTH-1:0] right_channel_audio_in,
  output logic                  overflow,
  output logic                  framing_error
`ifdef AUDIO_IN_PEAK_EN
  ,
  output logic [DATA_WIDTH-1:0] peak_level
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_bclk_last;
  logic                   r_lrck_last;
  logic                   w_bclk;
  logic                   w_lrck;
  logic                   w_dat;
  logic                   w_bclk_rise;
  logic                   w_lr_edge;

  frame_state_e           r_state;
  frame_state_e           w_state_next;
  logic                   r_channel;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_WIDTH-2:0]  r_shift;
  logic [DATA_WIDTH-1:0]  r_left;
  logic                   r_left_valid;
  logic                   r_overflow;
  logic                   r_framing_error;
  logic [DATA_WIDTH-1:0]  w_word;
  logic                   w_word_done;
  logic                   w_truncate;
  logic                   w_start;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [2*DATA_WIDTH-1:0] w_head;

  // All three serial lines share the same synchronizer depth, so data and
  // frame clock stay aligned with the bit clock they were launched against.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
      r_bclk_last <= 1'b0;
      r_lrck_last <= 1'b0;
    end else begin
      r_bclk_sync <= (r_bclk_sync << 1) | SYNC_STAGES'(AUD_BCLK);
      r_lrck_sync <= (r_lrck_sync << 1) | SYNC_STAGES'(AUD_ADCLRCK);
      r_dat_sync  <= (r_dat_sync << 1)  | SYNC_STAGES'(AUD_ADCDAT);
      r_bclk_last <= w_bclk;
      if (w_bclk_rise) r_lrck_last <= w_lrck;
    end
  end

  assign w_bclk      = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrck      = r_lrck_sync[SYNC_STAGES-1];
  assign w_dat       = r_dat_sync[SYNC_STAGES-1];
  assign w_bclk_rise = w_bclk && !r_bclk_last;
  assign w_lr_edge   = w_bclk_rise && (w_lrck != r_lrck_last);
  assign w_word      = {r_shift, w_dat};

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ALIGN;
    else        r_state <= w_state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_word_done  = 1'b0;
    w_truncate   = 1'b0;
    w_start      = 1'b0;
    if (w_bclk_rise) begin
      case (r_state)
        ALIGN: if (w_lr_edge && w_lrck == LEFT) begin
          w_start      = 1'b1;
          w_state_next = DELAY;
        end
        DELAY: w_state_next = SHIFT;
        SHIFT: begin
          if (w_lr_edge) begin
            w_truncate   = 1'b1;
            w_start      = 1'b1;
            w_state_next = DELAY;
          end else if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            w_word_done  = 1'b1;
            w_state_next = HOLD;
          end
        end
        HOLD: if (w_lr_edge) begin
          w_start      = 1'b1;
          w_state_next = DELAY;
        end
        default: w_state_next = ALIGN;
      endcase
    end
    if (clear_audio_in_memory) w_state_next = ALIGN;
  end

  // A new left word opens a new frame, so any older left word is forgotten.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_channel       <= LEFT;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_left          <= '0;
      r_left_valid    <= 1'b0;
      r_framing_error <= 1'b0;
    end else if (clear_audio_in_memory) begin
      r_left_valid    <= 1'b0;
      r_framing_error <= 1'b0;
    end else if (w_bclk_rise) begin
      if (w_start) begin
        r_channel <= w_lrck;
        if (w_lrck == LEFT) r_left_valid <= 1'b0;
      end
      if (r_state == DELAY) r_bit_cnt <= '0;
      if (r_state == SHIFT && !w_lr_edge) begin
        r_shift   <= w_word[DATA_WIDTH-2:0];
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_truncate) begin
        r_framing_error <= 1'b1;
        if (r_channel == LEFT) r_left_valid <= 1'b0;
      end
      if (w_word_done) begin
        if (r_channel == LEFT) begin
          r_left       <= w_word;
          r_left_valid <= 1'b1;
        end else begin
          r_left_valid <= 1'b0;
        end
      end
    end
  end

  assign w_push = w_word_done && (r_channel == RIGHT) && r_left_valid &&
                  !clear_audio_in_memory;
  assign w_pop  = read_audio_in && !w_empty;

  audio_in_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (clear_audio_in_memory),
    .i_push      (w_push),
    .i_push_data ({r_left, w_word}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset)                             r_overflow <= 1'b0;
    else if (clear_audio_in_memory)         r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop)    r_overflow <= 1'b1;
  end

  assign audio_in_available     = !w_empty;
  assign left_channel_audio_in  = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign right_channel_audio_in = w_head[DATA_WIDTH-1:0];
  assign overflow               = r_overflow;
  assign framing_error          = r_framing_error;

`ifdef AUDIO_IN_PEAK_EN
  logic [DATA_WIDTH-1:0] r_peak;
  logic [DATA_WIDTH-1:0] w_abs_left;
  logic [DATA_WIDTH-1:0] w_abs_right;
  logic [DATA_WIDTH-1:0] w_pair_peak;
  logic                  w_push_accept;

  // Magnitude of a two's-complement sample; the most negative code saturates.
  function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] v);
    if (!v[DATA_WIDTH-1])                       return v;
    if (v == {1'b1, {(DATA_WIDTH-1){1'b0}}})    return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return -v;
  endfunction

  assign w_abs_left    = abs_sat(r_left);
  assign w_abs_right   = abs_sat(w_word);
  assign w_pair_peak   = (w_abs_left > w_abs_right) ? w_abs_left : w_abs_right;
  assign w_push_accept = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset)                                   r_peak <= '0;
    else if (clear_audio_in_memory)               r_peak <= '0;
    else if (w_push_accept && w_pair_peak > r_peak) r_peak <= w_pair_peak;
  end

  assign peak_level = r_peak;
`endif

endmodule

// File: tb/tb_audio_in_receiver.sv
// Directed bench for audio_in_receiver: drives I2S frames slot by slot
// (LRCK edge slot, one delay slot, 32 MSB-first data bits, 2 idle slots).
module tb_audio_in_receiver;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          AUD_BCLK;
  logic          AUD_ADCLRCK;
  logic          AUD_ADCDAT;
  logic          clear_audio_in_memory;
  logic          read_audio_in;
  logic          audio_in_available;
  logic [DW-1:0] left_channel_audio_in;
  logic [DW-1:0] right_channel_audio_in;
  logic          overflow;
  logic          framing_error;
`ifdef AUDIO_IN_PEAK_EN
  logic [DW-1:0] peak_level;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int avail_rises = 0;
  logic avail_d = 1'b0;

  audio_in_receiver #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .AUD_BCLK               (AUD_BCLK),
    .AUD_ADCLRCK            (AUD_ADCLRCK),
    .AUD_ADCDAT             (AUD_ADCDAT),
    .clear_audio_in_memory  (clear_audio_in_memory),
    .read_audio_in          (read_audio_in),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .overflow               (overflow),
    .framing_error          (framing_error)
`ifdef AUDIO_IN_PEAK_EN
    ,
    .peak_level             (peak_level)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (audio_in_available === 1'b1 && avail_d === 1'b0) avail_rises++;
    avail_d <= audio_in_available;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One bit-clock period: line changes with BCLK low, rise after 3 clk cycles.
  // With rd_at_rise the read strobe lands on the clk edge where that rise is
  // acted upon (two synchronizer stages, then one edge).
  task automatic bclk_cycle(input logic lr, input logic d, input bit rd_at_rise);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    repeat (3) @(negedge clk);
    AUD_BCLK = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (rd_at_rise) read_audio_in = 1'b1;
    @(negedge clk);
    read_audio_in = 1'b0;
  endtask

  task automatic send_channel(input logic lr, input logic [31:0] word, input int nbits, input bit rd_last);
    bclk_cycle(lr, 1'b0, 1'b0);
    bclk_cycle(lr, 1'b1, 1'b0);
    for (int i = 0; i < nbits; i++) bclk_cycle(lr, word[31-i], rd_last && (i == nbits - 1));
    if (nbits == 32) begin
      bclk_cycle(lr, 1'b0, 1'b0);
      bclk_cycle(lr, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
    send_channel(1'b0, l, 32, 1'b0);
    send_channel(1'b1, r, 32, 1'b0);
  endtask

  task automatic pop_pair();
    read_audio_in = 1'b1;
    @(negedge clk);
    read_audio_in = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_audio_in_memory = 1'b1;
    @(negedge clk);
    clear_audio_in_memory = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] l, input logic [31:0] r);
    check({tag, " avail"}, 64'(audio_in_available), 64'd1);
    check({tag, " left"},  64'(left_channel_audio_in), 64'(l));
    check({tag, " right"}, 64'(right_channel_audio_in), 64'(r));
  endtask

  initial begin
    reset                 = 1'b0;
    AUD_BCLK              = 1'b0;
    AUD_ADCLRCK           = 1'b1;
    AUD_ADCDAT            = 1'b0;
    clear_audio_in_memory = 1'b0;
    read_audio_in         = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check("reset avail", 64'(audio_in_available), 64'd0);
    check("reset left", 64'(left_channel_audio_in), 64'd0);
    check("reset right", 64'(right_channel_audio_in), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset framing", 64'(framing_error), 64'd0);
    reset = 1'b1;

    // One frame, one read
    for (int i = 0; i < 4; i++) bclk_cycle(1'b1, 1'b0, 1'b0);
    send_frame(32'h1234_5678, 32'h9ABC_DEF0);
    check_head("t1", 32'h1234_5678, 32'h9ABC_DEF0);
    check("t1 rises", 64'(avail_rises), 64'd1);
    pop_pair();
    check("t1 empty", 64'(audio_in_available), 64'd0);
    check("t1 left zero", 64'(left_channel_audio_in), 64'd0);

    // Restart mid right channel: nothing until the first LRCK falling edge
    reset = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) bclk_cycle(1'b1, 1'(i % 3 == 0), 1'b0);
    check("t2 no capture", 64'(audio_in_available), 64'd0);
    send_frame(32'hDEAD_BEEF, 32'h0F0F_1234);
    check_head("t2", 32'hDEAD_BEEF, 32'h0F0F_1234);
    check("t2 framing", 64'(framing_error), 64'd0);
    pop_pair();
    check("t2 empty", 64'(audio_in_available), 64'd0);

    // Nine frames without reads: eight kept, overflow flagged
    for (int k = 1; k <= 9; k++) send_frame(32'hA000_0000 | 32'(k), 32'hB000_0000 | 32'(k));
    check("t3 overflow", 64'(overflow), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      check_head($sformatf("t3 pop%0d", k), 32'hA000_0000 | 32'(k), 32'hB000_0000 | 32'(k));
      pop_pair();
    end
    check("t3 empty", 64'(audio_in_available), 64'd0);

    // Left word cut after 20 bits
    send_channel(1'b0, 32'h5555_AAAA, 20, 1'b0);
    send_channel(1'b1, 32'h7777_8888, 32, 1'b0);
    check("t4 framing", 64'(framing_error), 64'd1);
    check("t4 no push", 64'(audio_in_available), 64'd0);
    send_frame(32'h0102_0304, 32'hF1F2_F3F4);
    check_head("t4 next", 32'h0102_0304, 32'hF1F2_F3F4);
    pop_pair();

    // Clear with three pairs queued and both flags set
    for (int k = 1; k <= 3; k++) send_frame(32'h5000_0000 | 32'(k), 32'h6000_0000 | 32'(k));
    check("t6 avail before", 64'(audio_in_available), 64'd1);
    check("t6 ovf before", 64'(overflow), 64'd1);
    check("t6 ferr before", 64'(framing_error), 64'd1);
    send_channel(1'b0, 32'hCAFE_F00D, 32, 1'b0);
    pulse_clear();
    check("t6 avail", 64'(audio_in_available), 64'd0);
    check("t6 left", 64'(left_channel_audio_in), 64'd0);
    check("t6 overflow", 64'(overflow), 64'd0);
    check("t6 framing", 64'(framing_error), 64'd0);
`ifdef AUDIO_IN_PEAK_EN
    check("t6 peak cleared", 64'(peak_level), 64'd0);
`endif
    send_channel(1'b1, 32'h1111_2222, 32, 1'b0);
    check("t6 realign", 64'(audio_in_available), 64'd0);
    send_frame(32'h8000_0000, 32'h0000_0005);
    check_head("t6 next", 32'h8000_0000, 32'h0000_0005);
    check("t6 framing after", 64'(framing_error), 64'd0);
`ifdef AUDIO_IN_PEAK_EN
    check("t6 peak", 64'(peak_level), 64'h7FFF_FFFF);
`endif
    pop_pair();

    // Push into a full FIFO together with a read
    for (int k = 1; k <= 8; k++) send_frame(32'h3000_0000 | 32'(k), 32'h4000_0000 | 32'(k));
    check("t5 ovf full", 64'(overflow), 64'd0);
    check_head("t5 head", 32'h3000_0001, 32'h4000_0001);
    send_channel(1'b0, 32'h3000_0009, 32, 1'b0);
    send_channel(1'b1, 32'h4000_0009, 32, 1'b1);
    check("t5 overflow", 64'(overflow), 64'd0);
    for (int k = 2; k <= 9; k++) begin
      check_head($sformatf("t5 pop%0d", k), 32'h3000_0000 | 32'(k), 32'h4000_0000 | 32'(k));
      pop_pair();
    end
    check("t5 empty", 64'(audio_in_available), 64'd0);

    // Read while empty is ignored
    pop_pair();
    check("empty read", 64'(audio_in_available), 64'd0);
    send_frame(32'h0BAD_CAFE, 32'h0000_FFFF);
    check_head("after empty read", 32'h0BAD_CAFE, 32'h0000_FFFF);
    pop_pair();
    check("final empty", 64'(audio_in_available), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/audio_in_receiver.md
Name: audio_in_receiver

Overview:
- Capture side of the WM8731 audio serial link; the counterpart of the DAC output path that my_tone feeds.
- Oversamples AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT in the system clock domain and deserializes I2S frames into left/right sample pairs.
- Buffers pairs in a small FIFO and presents them through a reader handshake: read_audio_in / audio_in_available.
- Sits beside audio_controller and feeds future input-driven features, e.g. a sound-triggered order key.

Parameters:
- DATA_WIDTH, 32: bits per channel word, MSB first.
- FIFO_DEPTH, 8: sample-pair entries; power of two, at least 2.
- SYNC_STAGES, 2: flip-flop stages on each serial input.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-low reset (asserted when 0).
- AUD_BCLK  in  1  codec bit clock, asynchronous to clk.
- AUD_ADCLRCK  in  1  codec frame clock: 0 = left, 1 = right.
- AUD_ADCDAT  in  1  codec serial data.
- clear_audio_in_memory  in  1  flush FIFO and realign framer.
- read_audio_in  in  1  pop the head pair when available.
- audio_in_available  out  1  FIFO non-empty.
- left_channel_audio_in  out  DATA_WIDTH  head-of-FIFO left word (show-ahead).
- right_channel_audio_in  out  DATA_WIDTH  head-of-FIFO right word.
- overflow  out  1  sticky: a pair was dropped.
- framing_error  out  1  sticky: a word was truncated by an LRCK edge.

Behaviour:
- Reset (reset==0 at a clk edge): FIFO empty, audio_in_available=0, both data outputs 0, overflow=0, framing_error=0, all synchronizers 0, FSM=ALIGN.
- Input sampling:
  - Each serial input passes through SYNC_STAGES flops.
  - bclk_rise = synced BCLK 0→1; lr_edge = any change of synced LRCK detected on a bclk_rise.
  - All framing acts only on bclk_rise cycles.
- FSM:
  - ALIGN: wait for an LRCK falling edge (left start), then go to DELAY. Nothing is captured before first alignment.
  - DELAY: skip one bclk_rise (I2S one-bit delay), then go to SHIFT with bit_cnt=0.
  - SHIFT: on each bclk_rise, shift in ADCDAT and increment bit_cnt. When bit_cnt reaches DATA_WIDTH, store the word into the left or right holding register per the channel bit, then go to HOLD.
  - HOLD: ignore data until lr_edge, then go to DELAY with channel=LRCK.
  - lr_edge during SHIFT: discard the partial word, set framing_error, go to DELAY for the new channel. A truncated left word invalidates that frame's pair.
- Push:
  - When a right word completes and a valid left word exists for the same frame, push {left,right} on the next clk.
  - If the FIFO is full, drop the pair and set overflow; FIFO contents are unchanged.
- Pop:
  - read_audio_in while audio_in_available advances the read pointer; outputs show the new head the following cycle.
  - read_audio_in while empty is ignored.
- Simultaneous push and pop on a full FIFO: both succeed, no overflow.
- Latency: a pair becomes visible 1 clk after the final right-channel bclk_rise, plus the SYNC_STAGES input delay.
- clear_audio_in_memory (1 cycle): empties the FIFO, zeroes the outputs, clears both sticky flags and returns the FSM to ALIGN. It takes priority over a push or pop in the same cycle.
- When the FIFO is empty, the data outputs hold 0.
- Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with one extra pointer bit.

Optional Feature:
- Macro: AUDIO_IN_PEAK_EN.
- When defined:
  - Adds output peak_level [DATA_WIDTH-1:0], reset 0.
  - On each push, peak_level = max(peak_level, |left|, |right|), treating samples as two's complement. |most-negative| saturates to 2^(DATA_WIDTH-1)-1.
  - peak_level is cleared by clear_audio_in_memory.
- When undefined: the port and logic are absent.

Decomposition:
- Shared package audio_pkg:
  - FSM state encoding ALIGN/DELAY/SHIFT/HOLD.
  - Channel constants LEFT=0, RIGHT=1.
  - Default DATA_WIDTH.
- One natural sub-module, audio_in_fifo: a synchronous show-ahead FIFO with push, pop, clear, full and empty.
- Synchronizers and the framer stay in the top module.

Test Plan:
- Reset held 4 cycles, then one I2S frame with L=32'h12345678, R=32'h9ABCDEF0 → audio_in_available rises once, outputs show both words, one read_audio_in empties the FIFO.
- Stream starting mid-right-channel → no capture until the first LRCK falling edge; the first pair is the next complete frame.
- 9 frames with no reads at FIFO_DEPTH=8 → 8 pairs held, overflow=1, reads return frames 1..8 in order.
- LRCK toggles after 20 bits of a left word → framing_error=1, that frame is not pushed, the next frame is captured normally.
- read_audio_in asserted on the same cycle as a push into a full FIFO → overflow stays 0, occupancy stays 8.
- clear_audio_in_memory with 3 pairs queued and both flags set → available=0, flags=0, realignment before the next capture; with AUDIO_IN_PEAK_EN and L=32'h80000000 → peak_level=32'h7FFFFFFF.
